fifo_uart_tx: RTL and testbench

Downstream consumer of the 8-bit synchronous FIFO. It pops one word at a time through the FIFO read handshake and serialises it onto a UART TX line: start bit, WIDTH data bits LSB first, optional parity, then 1 or 2 stop bits. It sits between the FIFO read port and the chip-level serial pin, and reports per-frame completion.

---
 rtl/fifo_uart_pkg.sv | 33 +++
 rtl/fifo_uart_tx_baud.sv | 38 +++
 rtl/fifo_uart_tx.sv | 147 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// line idle level and a frame-length helper.
package fifo_uart_pkg;

  // State codes (3 bits).
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] PARITY = 3'd5;
  localparam logic [2:0] STOP   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_FETCH  = FETCH,
    ST_LOAD   = LOAD,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_PARITY = PARITY,
    ST_STOP   = STOP
  } state_e;

  // Level driven on the serial line whenever no frame is in flight.
  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Serial bits in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int width, input int parity_en,
                                    input int stop_bits);
    return 1 + width + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Baud tick generator: free-running counter that wraps explicitly at
// CLKS_PER_BIT-1 and restarts from zero whenever clear is asserted, so every
// FSM state begins with a full bit period.
module baud_tick_gen
  #(parameter int CLKS_PER_BIT = 16)
  (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    output logic tick
  );

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: restart on clear or at the terminal count, else advance.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick is decoded from the registered count only.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter. Pops one word per frame through the FIFO read
// handshake and shifts it out LSB first with optional parity and 1 or 2 stop
// bits. All outputs are decoded from registered state.
//
// state  | meaning
// IDLE   | line high, waiting for tx_enable and a non-empty FIFO
// FETCH  | one-cycle read strobe to the FIFO
// LOAD   | capture FIFO word (and parity) into the shift register
// START  | start bit, line low for one bit period
// DATA   | data bits, LSB first
// PARITY | parity bit (only when PARITY_EN=1)
// STOP   | stop bit(s), frame_done on the very last cycle
module fifo_uart_tx
  import fifo_uart_pkg::*;
  #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
  )
  (
    input  logic             clock,
    input  logic             resetn,
    input  logic             tx_enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_read_enb,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
  );

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          USE_PAR   = (PARITY_EN != 0);
  localparam logic          ODD_PAR   = (PARITY_ODD != 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             parity_q, parity_d;
  logic             tick;
  logic             baud_clear;

  // Every state change restarts the bit-period counter.
  assign baud_clear = (state_d != state_q);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock  (clock),
    .resetn (resetn),
    .clear  (baud_clear),
    .tick   (tick)
  );

  // Next-state logic; fifo_data_out is only looked at in LOAD so a floating
  // FIFO bus can never leak onto the line.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_enable && !fifo_empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d   = fifo_data_out;
        parity_d  = USE_PAR ? ((^fifo_data_out) ^ ODD_PAR) : 1'b0;
        bit_cnt_d = '0;
        state_d   = ST_START;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = USE_PAR ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
    end
  end

  // Serial line level decoded from the registered state.
  always_comb begin
    tx = TX_IDLE_LEVEL;
    case (state_q)
      ST_START:  tx = ~TX_IDLE_LEVEL;
      ST_DATA:   tx = shift_q[0];
      ST_PARITY: tx = parity_q;
      default:   tx = TX_IDLE_LEVEL;
    endcase
  end

  assign busy          = (state_q != ST_IDLE);
  assign fifo_read_enb = (state_q == ST_FETCH);
  assign frame_done    = (state_q == ST_STOP) && tick && (bit_cnt_q == LAST_STOP);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (plain 8N1, even parity with two
// stop bits, odd parity with a 3-clock bit period) fed by behavioural FIFOs.
module tb_fifo_uart_tx;

  localparam int N = 3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic [N-1:0] en = '0;
  logic [N-1:0] empty_w, rd_w, tx_w, busy_w, done_w;
  logic [7:0]   dout [N];

  logic [7:0] fmem [N][64];
  int wp [N] = '{default: 0};
  int rp [N] = '{default: 0};

  logic [7:0] exp_q0[$], exp_q1[$], exp_q2[$];
  int starts0[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int frames_started [N] = '{default: 0};
  int frames_done    [N] = '{default: 0};
  int rd_cnt         [N] = '{default: 0};
  int last_rd        [N] = '{default: 0};
  logic [N-1:0] rd_prev = '0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clock(clock), .resetn(resetn), .tx_enable(en[0]), .fifo_empty(empty_w[0]),
    .fifo_data_out(dout[0]), .fifo_read_enb(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
    .frame_done(done_w[0]));

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clock(clock), .resetn(resetn), .tx_enable(en[1]), .fifo_empty(empty_w[1]),
    .fifo_data_out(dout[1]), .fifo_read_enb(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
    .frame_done(done_w[1]));

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clock(clock), .resetn(resetn), .tx_enable(en[2]), .fifo_empty(empty_w[2]),
    .fifo_data_out(dout[2]), .fifo_read_enb(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]),
    .frame_done(done_w[2]));

  function automatic int cpb_of(input int i);
    return (i == 2) ? 3 : 4;
  endfunction
  function automatic int pe_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction
  function automatic logic odd_of(input int i);
    return (i == 2);
  endfunction
  function automatic int sb_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  // Expected line level for serial bit idx of a frame carrying w.
  function automatic logic exp_bit(input int i, input logic [7:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    if (pe_of(i) == 1 && idx == 9) return (^w) ^ odd_of(i);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push_word(input int i, input logic [7:0] d);
    fmem[i][wp[i]] = d;
    wp[i] = wp[i] + 1;
    case (i)
      0:       exp_q0.push_back(d);
      1:       exp_q1.push_back(d);
      default: exp_q2.push_back(d);
    endcase
  endtask

  function automatic bit pop_exp(input int i, output logic [7:0] w);
    w = 8'h00;
    pop_exp = 1'b0;
    case (i)
      0:       if (exp_q0.size() > 0) begin w = exp_q0.pop_front(); pop_exp = 1'b1; end
      1:       if (exp_q1.size() > 0) begin w = exp_q1.pop_front(); pop_exp = 1'b1; end
      default: if (exp_q2.size() > 0) begin w = exp_q2.pop_front(); pop_exp = 1'b1; end
    endcase
  endfunction

  // Behavioural FIFOs: word valid in the cycle after a read strobe, junk otherwise.
  always_comb begin
    for (int i = 0; i < N; i++) empty_w[i] = (wp[i] == rp[i]);
  end

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (rd_w[i] && (rp[i] != wp[i])) begin
        dout[i] <= fmem[i][rp[i]];
        rp[i]   <= rp[i] + 1;
      end else begin
        dout[i] <= 8'($urandom);
      end
    end
  end

  // Read strobe watcher.
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (rd_w[i]) begin
        chk($sformatf("u%0d_rd_while_empty", i), empty_w[i], 1'b0);
        chk($sformatf("u%0d_rd_double", i), rd_prev[i], 1'b0);
        rd_cnt[i]  = rd_cnt[i] + 1;
        last_rd[i] = cyc;
      end
      rd_prev[i] = rd_w[i];
    end
  end

  // Frame monitor: checks every cycle of every frame against the scoreboard.
  task automatic mon(input int i);
    logic [7:0] w;
    bit got;
    bit aborted;
    int cpb, ncyc;
    forever begin
      @(negedge clock);
      if (resetn && tx_w[i] == 1'b0) begin
        frames_started[i] = frames_started[i] + 1;
        if (i == 0) starts0.push_back(cyc);
        chk($sformatf("u%0d_latency", i), cyc - last_rd[i], 2);
        got = pop_exp(i, w);
        chk($sformatf("u%0d_frame_expected", i), got, 1'b1);
        cpb  = cpb_of(i);
        ncyc = (1 + 8 + pe_of(i) + sb_of(i)) * cpb;
        aborted = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
          if (k > 0) @(negedge clock);
          if (!resetn) begin
            aborted = 1'b1;
            break;
          end
          chk($sformatf("u%0d_tx_bit%0d", i, k / cpb), tx_w[i], exp_bit(i, w, k / cpb));
          chk($sformatf("u%0d_frame_done", i), done_w[i], (k == ncyc - 1));
          chk($sformatf("u%0d_busy", i), busy_w[i], 1'b1);
        end
        if (!aborted) frames_done[i] = frames_done[i] + 1;
      end else begin
        chk($sformatf("u%0d_idle_done", i), done_w[i], 1'b0);
      end
    end
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none
  end

  task automatic wait_count(input int i, input bit started, input int target,
                            input int budget, input string tag);
    int k = 0;
    while (((started ? frames_started[i] : frames_done[i]) < target) && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(tag, (started ? frames_started[i] : frames_done[i]) >= target, 1'b1);
  endtask

  initial begin : main
    int s0;
    resetn = 1'b0;
    en     = '0;
    repeat (3) @(negedge clock);
    chk("rst_tx", tx_w, 3'b111);
    chk("rst_busy", busy_w, 3'b000);
    chk("rst_rd", rd_w, 3'b000);
    chk("rst_done", done_w, 3'b000);
    resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk("idle_tx", tx_w[0], 1'b1);
      chk("idle_busy", busy_w[0], 1'b0);
    end
    chk("idle_reads", rd_cnt[0], 0);

    // Single 0xA5 frame.
    push_word(0, 8'hA5);
    en[0] = 1'b1;
    wait_count(0, 1'b0, 1, 200, "a5_timeout");
    chk("a5_reads", rd_cnt[0], 1);
    chk("a5_empty", empty_w[0], 1'b1);

    // Parity: even 0x07, even 0x00 (two stop bits), odd 0x07.
    push_word(1, 8'h07);
    push_word(1, 8'h00);
    push_word(2, 8'h07);
    en[1] = 1'b1;
    en[2] = 1'b1;
    wait_count(1, 1'b0, 2, 400, "par_even_timeout");
    wait_count(2, 1'b0, 1, 400, "par_odd_timeout");
    chk("par_even_reads", rd_cnt[1], 2);
    chk("par_odd_reads", rd_cnt[2], 1);

    // Preloaded burst of 16 words.
    en[0] = 1'b0;
    for (int w = 0; w < 16; w++) push_word(0, 8'(w));
    @(negedge clock);
    chk("burst_no_read_disabled", rd_cnt[0], 1);
    chk("burst_not_empty", empty_w[0], 1'b0);
    s0 = starts0.size();
    en[0] = 1'b1;
    wait_count(0, 1'b0, 17, 1000, "burst_timeout");
    chk("burst_reads", rd_cnt[0], 17);
    chk("burst_empty", empty_w[0], 1'b1);
    for (int k = s0 + 1; k < s0 + 16 && k < starts0.size(); k++)
      chk("burst_gap", starts0[k] - starts0[k-1], 43);
    repeat (20) @(negedge clock);
    chk("burst_no_more_reads", rd_cnt[0], 17);

    // Asynchronous reset in the middle of 0xFF's data bits.
    push_word(0, 8'hFF);
    wait_count(0, 1'b1, 18, 50, "ff_start_timeout");
    repeat (12) @(negedge clock);
    chk("pre_rst_busy", busy_w[0], 1'b1);
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_tx", tx_w[0], 1'b1);
    chk("async_rst_busy", busy_w[0], 1'b0);
    repeat (3) @(negedge clock);
    #1 resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("post_rst_tx", tx_w[0], 1'b1);
      chk("post_rst_busy", busy_w[0], 1'b0);
    end
    chk("post_rst_reads", rd_cnt[0], 18);

    // tx_enable dropped during the start bit of a two-word queue.
    en[0] = 1'b0;
    push_word(0, 8'h3C);
    push_word(0, 8'hC3);
    en[0] = 1'b1;
    wait_count(0, 1'b1, 19, 50, "hold_start_timeout");
    en[0] = 1'b0;
    wait_count(0, 1'b0, 18, 100, "hold_frame_timeout");
    repeat (20) @(negedge clock);
    chk("hold_reads", rd_cnt[0], 19);
    chk("hold_not_empty", empty_w[0], 1'b0);
    chk("hold_busy", busy_w[0], 1'b0);
    en[0] = 1'b1;
    wait_count(0, 1'b0, 19, 100, "resume_timeout");
    chk("resume_reads", rd_cnt[0], 20);
    chk("resume_empty", empty_w[0], 1'b1);

    chk("sb_left0", exp_q0.size(), 0);
    chk("sb_left1", exp_q1.size(), 0);
    chk("sb_left2", exp_q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
